// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus engine and the sequencers that drive it.
// Holds the bus-cycle state encoding, default phase timing and RTC register map.
package rtc_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ADDR_GAP = 3'd2,
      ST_DATA     = 3'd3,
      ST_REC      = 3'd4
   } bus_state_t;

   localparam int unsigned T_PULSE_DEF = 7;
   localparam int unsigned T_GAP_DEF   = 7;

   // RTC register map and command codes
   localparam logic [7:0] RTC_STATUS0   = 8'h00;
   localparam logic [7:0] RTC_STATUS1   = 8'h01;
   localparam logic [7:0] RTC_STATUS2   = 8'h02;
   localparam logic [7:0] RTC_DIG_TRIM  = 8'h03;
   localparam logic [7:0] RTC_SEC       = 8'h10;
   localparam logic [7:0] RTC_MIN       = 8'h11;
   localparam logic [7:0] RTC_HOUR      = 8'h12;
   localparam logic [7:0] RTC_WEEKDAY   = 8'h13;
   localparam logic [7:0] RTC_DAY       = 8'h14;
   localparam logic [7:0] RTC_MONTH     = 8'h15;
   localparam logic [7:0] RTC_YEAR      = 8'h16;
   localparam logic [7:0] RTC_TIMER_CTL = 8'h20;
   localparam logic [7:0] RTC_TIMER_CNT = 8'h21;
   localparam logic [7:0] RTC_CMD_F1    = 8'hF1;
   localparam logic [7:0] RTC_CMD_F2    = 8'hF2;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing one bus phase; expired is high in the phase's last cycle.
// Zero latency on expired (decoded from the count register); no backpressure.
module rtc_phase_timer #(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == CNT_W'(1));

endmodule

// File: rtl/rtc_bus_master.sv
// Two-phase (address then data) RTC bus cycle engine with registered strobes.
// One transaction at a time: req_i is acked on entry to ADDR, done_o 2*(T_PULSE+T_GAP) cycles later.
module rtc_bus_master
   import rtc_bus_pkg::*;
#(
   parameter int unsigned T_PULSE = T_PULSE_DEF,
   parameter int unsigned T_GAP   = T_GAP_DEF,
   parameter int unsigned CNT_W   = 5
) (
   input  logic       clk_i,
   input  logic       reset,
   input  logic       req_i,
   input  logic       rnw_i,
   input  logic [7:0] addr_i,
   input  logic [7:0] wdata_i,
   output logic       ack_o,
   output logic       busy_o,
   output logic       done_o,
   output logic [7:0] rdata_o,
   output logic [7:0] bus_data_o,
   output logic       bus_oe_o,
   input  logic [7:0] bus_data_i,
   output logic       ad_o,
   output logic       cs_o,
   output logic       rd_o,
   output logic       wr_o
);

   bus_state_t       state, state_n;
   logic [7:0]       addr_q, wdata_q, addr_nx, wdata_nx;
   logic             rnw_q, rnw_nx;
   logic             expired, accept, finish, load;
   logic [CNT_W-1:0] load_val;
   logic             cs_n, rd_n, wr_n, ad_n, oe_n, busy_n;
   logic [7:0]       bdat_n;

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      finish  = 1'b0;
      case (state)
         ST_IDLE:     accept = req_i;
         ST_ADDR:     if (expired) state_n = ST_ADDR_GAP;
         ST_ADDR_GAP: if (expired) state_n = ST_DATA;
         ST_DATA:     if (expired) state_n = ST_REC;
         ST_REC: begin
            if (expired) begin
               finish  = 1'b1;
               accept  = req_i;
               state_n = ST_IDLE;
            end
         end
         default:     state_n = ST_IDLE;
      endcase
      // A request in the final recovery cycle chains straight into the next address phase
      if (accept) state_n = ST_ADDR;
   end

   always_comb begin
      load     = (state_n != state);
      load_val = '0;
      case (state_n)
         ST_ADDR, ST_DATA:    load_val = CNT_W'(T_PULSE);
         ST_ADDR_GAP, ST_REC: load_val = CNT_W'(T_GAP);
         default:             load_val = '0;
      endcase
   end

   rtc_phase_timer #(
      .CNT_W   (CNT_W)
   ) u_timer (
      .clk     (clk_i),
      .rst_n   (reset),
      .load    (load),
      .load_val(load_val),
      .expired (expired)
   );

   // Outputs are decoded from the next state so they register in step with it
   always_comb begin
      addr_nx  = accept ? addr_i  : addr_q;
      wdata_nx = accept ? wdata_i : wdata_q;
      rnw_nx   = accept ? rnw_i   : rnw_q;
      cs_n     = 1'b1;
      rd_n     = 1'b1;
      wr_n     = 1'b1;
      ad_n     = 1'b0;
      oe_n     = 1'b0;
      bdat_n   = 8'h00;
      busy_n   = 1'b1;
      case (state_n)
         ST_IDLE: busy_n = 1'b0;
         ST_ADDR: begin
            cs_n   = 1'b0;
            wr_n   = 1'b0;
            oe_n   = 1'b1;
            bdat_n = addr_nx;
         end
         ST_ADDR_GAP: begin
            oe_n   = 1'b1;
            bdat_n = addr_nx;
         end
         ST_DATA: begin
            cs_n = 1'b0;
            ad_n = 1'b1;
            if (rnw_nx) begin
               rd_n = 1'b0;
            end else begin
               wr_n   = 1'b0;
               oe_n   = 1'b1;
               bdat_n = wdata_nx;
            end
         end
         ST_REC:  ad_n = 1'b1;
         default: busy_n = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         addr_q     <= 8'h00;
         wdata_q    <= 8'h00;
         rnw_q      <= 1'b0;
         rdata_o    <= 8'h00;
         ack_o      <= 1'b0;
         done_o     <= 1'b0;
         busy_o     <= 1'b0;
         cs_o       <= 1'b1;
         rd_o       <= 1'b1;
         wr_o       <= 1'b1;
         ad_o       <= 1'b0;
         bus_oe_o   <= 1'b0;
         bus_data_o <= 8'h00;
      end else begin
         state      <= state_n;
         addr_q     <= addr_nx;
         wdata_q    <= wdata_nx;
         rnw_q      <= rnw_nx;
         ack_o      <= accept;
         done_o     <= finish;
         busy_o     <= busy_n;
         cs_o       <= cs_n;
         rd_o       <= rd_n;
         wr_o       <= wr_n;
         ad_o       <= ad_n;
         bus_oe_o   <= oe_n;
         bus_data_o <= bdat_n;
         if (state == ST_DATA && expired && rnw_q) rdata_o <= bus_data_i;
      end
   end

endmodule
